sm_fetch_sched: RTL

//  Per-SM instruction-fetch scheduler. Holds a PC and an active bit per warp, and picks one eligible warp

---
 rtl/sm_pkg.sv | 13 +
 rtl/sm_rr_arbiter.sv | 29 ++
 rtl/sm_fetch_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sm_pkg.sv
// Shared types and sizes for the SM front end.
package sm_pkg;
   localparam int NUM_WARP   = 8;
   localparam int DEPTH_WARP = $clog2(NUM_WARP);
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } fetch_state_e;
endpackage

// File: rtl/sm_rr_arbiter.sv
// Round-robin arbiter: first request at or after i_ptr, wrapping at N-1.
// Combinational; the caller decides when its pointer advances.
module sm_rr_arbiter #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_grant_onehot,
   output logic [W-1:0] o_grant_idx,
   output logic         o_any
);
   logic [W-1:0] w_idx;

   always_comb begin
      o_grant_onehot = '0;
      o_grant_idx    = '0;
      o_any          = 1'b0;
      w_idx          = '0;
      for (int i = 0; i < N; i++) begin
         w_idx = W'((int'(i_ptr) + i) % N);
         if (!o_any && i_req[w_idx]) begin
            o_any                 = 1'b1;
            o_grant_onehot[w_idx] = 1'b1;
            o_grant_idx           = w_idx;
         end
      end
   end
endmodule

// File: rtl/sm_fetch_sched.sv
// Per-SM fetch scheduler: round-robin warp pick, one outstanding
// code-memory read, tagged instruction handoff to the ibuffer.
module sm_fetch_sched
   import sm_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  warp_start_valid_i,
   input  logic [DEPTH_WARP-1:0] warp_start_wid_i,
   input  logic [ADDR_W-1:0]     warp_start_addr_i,
   input  logic                  warp_exit_valid_i,
   input  logic [DEPTH_WARP-1:0] warp_exit_wid_i,
   input  logic                  branch_valid_i,
   input  logic [DEPTH_WARP-1:0] branch_wid_i,
   input  logic [ADDR_W-1:0]     branch_target_i,
   input  logic [NUM_WARP-1:0]   inst_buffer_avail_i,
   input  logic                  code_mem_available_i,
   output logic                  code_read_valid_o,
   output logic [ADDR_W-1:0]     code_read_addr_o,
   output logic [DEPTH_WARP-1:0] code_read_wid_o,
   input  logic                  code_read_ready_i,
   input  logic [DATA_W-1:0]     code_read_data_i,
   output logic                  fetch_valid_o,
   output logic [DEPTH_WARP-1:0] fetch_wid_o,
   output logic [ADDR_W-1:0]     fetch_pc_o,
   output logic [DATA_W-1:0]     fetch_inst_o,
   output logic [NUM_WARP-1:0]   warp_active_o
);
   fetch_state_e          r_state, w_state_nxt;
   logic [NUM_WARP-1:0]   r_active;
   logic [ADDR_W-1:0]     r_pc [NUM_WARP];
   logic [DEPTH_WARP-1:0] r_ptr, r_wid;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_squash;
   logic                  r_fetch_valid;
   logic [DEPTH_WARP-1:0] r_fetch_wid;
   logic [ADDR_W-1:0]     r_fetch_pc;
   logic [DATA_W-1:0]     r_fetch_inst;

   logic [NUM_WARP-1:0]   w_start_hit, w_exit_hit, w_br_hit;
   logic [NUM_WARP-1:0]   w_elig, w_grant_oh;
   logic [DEPTH_WARP-1:0] w_grant_idx;
   logic [ADDR_W-1:0]     w_pick_pc;
   logic                  w_any, w_take, w_done, w_kill, w_deliver;

   always_comb begin
      w_start_hit = '0;
      w_exit_hit  = '0;
      w_br_hit    = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         w_start_hit[w] = warp_start_valid_i &&
                          (warp_start_wid_i == DEPTH_WARP'(w));
         w_exit_hit[w]  = warp_exit_valid_i &&
                          (warp_exit_wid_i == DEPTH_WARP'(w));
         w_br_hit[w]    = branch_valid_i &&
                          (branch_wid_i == DEPTH_WARP'(w));
      end
   end

   assign w_elig = r_active & inst_buffer_avail_i & ~w_br_hit;

   sm_rr_arbiter #(.N(NUM_WARP)) u_arb (
      .i_req          (w_elig),
      .i_ptr          (r_ptr),
      .o_grant_onehot (w_grant_oh),
      .o_grant_idx    (w_grant_idx),
      .o_any          (w_any)
   );

   always_comb begin
      w_pick_pc = '0;
      for (int w = 0; w < NUM_WARP; w++)
         if (w_grant_oh[w]) w_pick_pc = w_pick_pc | r_pc[w];
   end

   // An exit or redirect of the in-flight warp invalidates its fetch.
   assign w_kill    = w_exit_hit[r_wid] | w_br_hit[r_wid];
   assign w_deliver = w_done && !r_squash && !w_kill;

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = REQ;
               w_take      = 1'b1;
            end
         end
         REQ: begin
            if (w_kill)                    w_state_nxt = IDLE;
            else if (code_mem_available_i) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (code_read_ready_i) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active      <= '0;
         r_ptr         <= '0;
         r_wid         <= '0;
         r_addr        <= '0;
         r_squash      <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_fetch_wid   <= '0;
         r_fetch_pc    <= '0;
         r_fetch_inst  <= '0;
         for (int w = 0; w < NUM_WARP; w++) r_pc[w] <= '0;
      end else begin
         if (w_take) begin
            r_wid  <= w_grant_idx;
            r_addr <= w_pick_pc;
            r_ptr  <= w_grant_idx + 1'b1;
         end
         if (r_state == WAIT)
            r_squash <= w_done ? 1'b0 : (r_squash | w_kill);
         r_fetch_valid <= w_deliver;
         if (w_deliver) begin
            r_fetch_wid  <= r_wid;
            r_fetch_pc   <= r_addr;
            r_fetch_inst <= code_read_data_i;
         end
         for (int w = 0; w < NUM_WARP; w++) begin
            if (w_exit_hit[w]) begin
               r_active[w] <= 1'b0;
            end else if (w_br_hit[w] && r_active[w]) begin
               r_pc[w] <= branch_target_i;
            end else if (w_start_hit[w] && !r_active[w]) begin
               r_active[w] <= 1'b1;
               r_pc[w]     <= warp_start_addr_i;
            end else if (w_deliver && r_wid == DEPTH_WARP'(w)) begin
               r_pc[w] <= r_pc[w] + 1'b1;
            end
         end
      end
   end

   assign code_read_valid_o = (r_state == REQ);
   assign code_read_addr_o  = r_addr;
   assign code_read_wid_o   = r_wid;
   assign fetch_valid_o     = r_fetch_valid;
   assign fetch_wid_o       = r_fetch_wid;
   assign fetch_pc_o        = r_fetch_pc;
   assign fetch_inst_o      = r_fetch_inst;
   assign warp_active_o     = r_active;
endmodule
